fetcher: RTL and testbench
==========================

# fetcher

Instruction fetch unit sitting between the PC address controller and the decoder. It accepts one fetch request at a time (address plus branch-prediction bit), looks it up in a direct-mapped instruction cache, and on a miss fetches the 32-bit word from the memory controller. It returns the fetched instruction to the PC controller as a one-cycle pulse so the next address can be computed, and forwards instruction, PC and prediction to the decoder. A ROB flush aborts any in-flight fetch.

## Interface
Parameters:
- ICACHE_INDEX_BITS, 8: cache has 2^ICACHE_INDEX_BITS entries; index = addr[ICACHE_INDEX_BITS+1:2], tag = addr[31:ICACHE_INDEX_BITS+2].

Ports:
- in_clk  input  1  clock, all state on rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_rdy  input  1  global ready; low freezes all state.
- in_flush_enable  input  1  ROB misprediction flush.
- in_pc_enable  input  1  fetch request valid (single-cycle).
- in_pc_addr  input  32  fetch address, word-aligned.
- in_pc_predict  input  1  prediction bit travelling with the instruction.
- out_pc_last_enable  output  1  one-cycle pulse: instruction for last request ready.
- out_pc_last_inst  output  32  instruction returned to PC controller.
- out_mem_enable  output  1  memory read request, held until served or aborted.
- out_mem_addr  output  32  memory read address.
- in_mem_valid  input  1  memory word valid (only meaningful while out_mem_enable high).
- in_mem_inst  input  32  memory read data.
- out_decoder_enable  output  1  one-cycle pulse: instruction valid for decoder.
- out_decoder_inst  output  32  instruction.
- out_decoder_pc  output  32  its address.
- out_decoder_predict  output  1  its prediction bit.

## Operation
- States: IDLE, MISS.
- IDLE + in_pc_enable: latch addr/predict. Hit (entry valid and tag match): next edge pulse out_pc_last_enable and out_decoder_enable, drive inst/pc/predict; remain IDLE. Miss: next edge enter MISS, out_mem_enable=1, out_mem_addr=latched addr.
- MISS: hold out_mem_enable/out_mem_addr stable. On edge sampling in_mem_valid=1: write cache entry (data, tag, valid=1), pulse both output enables with in_mem_inst, drop out_mem_enable, return to IDLE.
- Protocol rule: at most one outstanding request; PC issues the next request only after out_pc_last_enable. in_pc_enable in MISS is a protocol violation; fetcher ignores it (bench asserts it never occurs).
- Flush: on edge with in_flush_enable=1, go to IDLE, drop out_mem_enable, suppress any pending output pulse; cache contents retained (no invalidation). A memory response arriving the same edge is discarded and not written to cache.
- Flush and in_pc_enable on the same edge: request is the redirect target and is accepted (lookup as normal from IDLE).
- in_rdy low: state, cache and latched request frozen; output enable pulses forced low; out_mem_enable held at current value.
- Output data registers (inst/pc/predict) hold last values between pulses; only enables pulse.

## Timing
- Reset (async): state IDLE, all valid bits 0, every output 0 (enables, inst, pc, predict, mem addr).
- Hit latency: request sampled at edge N -> enables high after edge N+1, low after edge N+2.
- Miss latency: request at edge N -> out_mem_enable high after N+1; in_mem_valid sampled at edge M -> enables pulse after M+1? No: pulse after edge M (registered together with cache write), low after M+1.
- Output enables are never high two consecutive cycles for one request; low for at least one cycle between pulses.
- Reset mid-MISS: immediate return to IDLE, out_mem_enable=0, cache cleared.

## Test plan
- Cold miss: reset, request 0x0 predict 0; mem returns 0x00000013 two cycles after out_mem_enable -> out_mem_addr=0x0, single pulse with inst 0x00000013, pc 0x0, predict 0.
- Hit: re-request 0x0 -> no out_mem_enable, pulse exactly one cycle after request with 0x00000013.
- Conflict: fill 0x0, then request 0x400 (same index, ICACHE_INDEX_BITS=8) -> miss, new word replaces entry; request 0x0 again -> miss.
- Flush during MISS: request 0x80, flush before in_mem_valid -> out_mem_enable drops next cycle, no pulse; later request 0x80 -> still misses (nothing written).
- Flush with redirect same cycle: flush + request 0x100 (cached, predict 1) -> pulse next cycle, pc 0x100, predict 1.
- in_rdy low for 3 cycles mid-MISS with in_mem_valid high -> no state change, no pulse; completes after in_rdy returns.

Source files
------------

// File: rtl/fetcher.sv
// Instruction fetch unit: direct-mapped I-cache lookup with a single outstanding
// memory miss, returning each fetched word to the PC controller and the decoder.
module fetcher #(
  parameter int unsigned ICACHE_INDEX_BITS = 8
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_rdy,
  input  logic        in_flush_enable,
  input  logic        in_pc_enable,
  input  logic [31:0] in_pc_addr,
  input  logic        in_pc_predict,
  output logic        out_pc_last_enable,
  output logic [31:0] out_pc_last_inst,
  output logic        out_mem_enable,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_valid,
  input  logic [31:0] in_mem_inst,
  output logic        out_decoder_enable,
  output logic [31:0] out_decoder_inst,
  output logic [31:0] out_decoder_pc,
  output logic        out_decoder_predict
);

  localparam int unsigned DEPTH = 1 << ICACHE_INDEX_BITS;
  localparam int unsigned TAG_W = 32 - ICACHE_INDEX_BITS - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Latched request; lookup_q marks a request awaiting its cache lookup
  logic                   lookup_q, lookup_d;
  logic [31:0]            req_addr_q, req_addr_d;
  logic                   req_pred_q, req_pred_d;

  logic                   pulse_q, pulse_d;
  logic [31:0]            inst_q, inst_d;
  logic [31:0]            pc_q, pc_d;
  logic                   pred_q, pred_d;
  logic                   mem_en_q, mem_en_d;
  logic [31:0]            mem_addr_q, mem_addr_d;

  logic [DEPTH-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [DEPTH];
  logic [31:0]            data_q [DEPTH];

  logic [ICACHE_INDEX_BITS-1:0] idx_c;
  logic [TAG_W-1:0]             req_tag_c;
  logic                         hit_c;
  logic                         cache_we_c;

  assign idx_c     = req_addr_q[ICACHE_INDEX_BITS+1:2];
  assign req_tag_c = req_addr_q[31:ICACHE_INDEX_BITS+2];
  assign hit_c     = valid_q[idx_c] && (tag_q[idx_c] == req_tag_c);

  // Next-state and output logic; in_rdy low leaves everything but the pulses untouched
  always_comb begin
    state_d    = state_q;
    lookup_d   = lookup_q;
    req_addr_d = req_addr_q;
    req_pred_d = req_pred_q;
    pulse_d    = 1'b0;
    inst_d     = inst_q;
    pc_d       = pc_q;
    pred_d     = pred_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    cache_we_c = 1'b0;

    if (in_rdy) begin
      if (in_flush_enable) begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        lookup_d = 1'b0;
        if (in_pc_enable) begin
          lookup_d   = 1'b1;
          req_addr_d = in_pc_addr;
          req_pred_d = in_pc_predict;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (lookup_q) begin
              lookup_d = 1'b0;
              if (hit_c) begin
                pulse_d = 1'b1;
                inst_d  = data_q[idx_c];
                pc_d    = req_addr_q;
                pred_d  = req_pred_q;
              end else begin
                state_d    = MISS;
                mem_en_d   = 1'b1;
                mem_addr_d = req_addr_q;
              end
            end else if (in_pc_enable) begin
              lookup_d   = 1'b1;
              req_addr_d = in_pc_addr;
              req_pred_d = in_pc_predict;
            end
          end
          MISS: begin
            if (in_mem_valid) begin
              cache_we_c = 1'b1;
              pulse_d    = 1'b1;
              inst_d     = in_mem_inst;
              pc_d       = req_addr_q;
              pred_d     = req_pred_q;
              mem_en_d   = 1'b0;
              state_d    = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= IDLE;
      lookup_q   <= 1'b0;
      req_addr_q <= 32'd0;
      req_pred_q <= 1'b0;
      pulse_q    <= 1'b0;
      inst_q     <= 32'd0;
      pc_q       <= 32'd0;
      pred_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      lookup_q   <= lookup_d;
      req_addr_q <= req_addr_d;
      req_pred_q <= req_pred_d;
      pulse_q    <= pulse_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      pred_q     <= pred_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      if (cache_we_c) begin
        valid_q[idx_c] <= 1'b1;
      end
    end
  end

  // Tag and data storage need no reset; valid bits gate every use
  always_ff @(posedge in_clk) begin
    if (cache_we_c) begin
      tag_q[idx_c]  <= req_tag_c;
      data_q[idx_c] <= in_mem_inst;
    end
  end

  assign out_pc_last_enable  = pulse_q;
  assign out_pc_last_inst    = inst_q;
  assign out_decoder_enable  = pulse_q;
  assign out_decoder_inst    = inst_q;
  assign out_decoder_pc      = pc_q;
  assign out_decoder_predict = pred_q;
  assign out_mem_enable      = mem_en_q;
  assign out_mem_addr        = mem_addr_q;

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: directed requests push expected decoder words,
// an independent monitor pops and compares on every output pulse.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        pc_en;
  logic [31:0] pc_addr;
  logic        pc_pred;
  logic        last_en;
  logic [31:0] last_inst;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_inst;
  logic        dec_en;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  exp_t sb_q[$];

  fetcher #(.ICACHE_INDEX_BITS(8)) dut (
    .in_clk             (clk),
    .in_rst             (rst),
    .in_rdy             (rdy),
    .in_flush_enable    (flush),
    .in_pc_enable       (pc_en),
    .in_pc_addr         (pc_addr),
    .in_pc_predict      (pc_pred),
    .out_pc_last_enable (last_en),
    .out_pc_last_inst   (last_inst),
    .out_mem_enable     (mem_en),
    .out_mem_addr       (mem_addr),
    .in_mem_valid       (mem_valid),
    .in_mem_inst        (mem_inst),
    .out_decoder_enable (dec_en),
    .out_decoder_inst   (dec_inst),
    .out_decoder_pc     (dec_pc),
    .out_decoder_predict(dec_pred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && (dec_en || last_en)) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got pc 0x%08h inst 0x%08h want no pulse", dec_pc, dec_inst);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (!(dec_en && last_en) || dec_inst !== e.inst || last_inst !== e.inst ||
            dec_pc !== e.pc || dec_pred !== e.pred) begin
          bad++;
          $display("FAIL pulse_data: got en %b/%b inst 0x%08h/0x%08h pc 0x%08h pred %b want inst 0x%08h pc 0x%08h pred %b",
                   dec_en, last_en, dec_inst, last_inst, dec_pc, dec_pred, e.inst, e.pc, e.pred);
        end
      end
    end
  end

  // PC must not issue a new request while a miss is outstanding (flush redirect excepted)
  always @(posedge clk) begin
    if (!rst && pc_en && mem_en && !flush) begin
      total++;
      bad++;
      $display("FAIL protocol: got request during MISS want none");
    end
  end

  task automatic issue(input logic [31:0] a, input logic p);
    pc_en = 1'b1; pc_addr = a; pc_pred = p;
    @(negedge clk);
    pc_en = 1'b0;
  endtask

  task automatic req_hit(input logic [31:0] a, input logic p, input logic [31:0] inst);
    sb_q.push_back('{inst: inst, pc: a, pred: p});
    issue(a, p);
    chk("hit_wait_en", 32'(dec_en), 32'd0);
    @(negedge clk);
    chk("hit_pulse", 32'(dec_en), 32'd1);
    chk("hit_no_mem", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("hit_pulse_end", 32'(dec_en), 32'd0);
  endtask

  task automatic req_miss(input logic [31:0] a, input logic p, input logic [31:0] inst, input int dly);
    sb_q.push_back('{inst: inst, pc: a, pred: p});
    issue(a, p);
    chk("miss_mem_lat", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("miss_mem_en", 32'(mem_en), 32'd1);
    chk("miss_mem_addr", mem_addr, a);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("miss_mem_hold", {31'd0, mem_en} | (mem_addr ^ a), 32'd1);
    end
    mem_valid = 1'b1; mem_inst = inst;
    @(negedge clk);
    mem_valid = 1'b0; mem_inst = 32'hx;
    chk("miss_pulse", 32'(dec_en), 32'd1);
    chk("miss_mem_drop", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("miss_pulse_end", 32'(dec_en), 32'd0);
  endtask

  task automatic start_miss(input logic [31:0] a);
    issue(a, 1'b0);
    @(negedge clk);
    chk("start_miss_en", 32'(mem_en), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; pc_en = 1'b0; pc_addr = 32'd0;
    pc_pred = 1'b0; mem_valid = 1'b0; mem_inst = 32'd0;
    #12;
    chk("rst_dec_en", 32'(dec_en), 32'd0);
    chk("rst_last_en", 32'(last_en), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_dec_inst", dec_inst | last_inst | dec_pc | 32'(dec_pred), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, then hit
    req_miss(32'h0, 1'b0, 32'h0000_0013, 2);
    req_hit(32'h0, 1'b0, 32'h0000_0013);
    req_miss(32'h100, 1'b1, 32'h0010_0093, 1);

    // Conflict on index 0
    req_miss(32'h400, 1'b0, 32'h0020_0113, 0);
    req_hit(32'h400, 1'b0, 32'h0020_0113);
    req_miss(32'h0, 1'b0, 32'h0000_0013, 1);

    // Flush during MISS aborts with no pulse and no fill
    start_miss(32'h80);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_mem_drop", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("flush_no_pulse", 32'(dec_en), 32'd0);
    req_miss(32'h80, 1'b0, 32'h0030_0193, 1);

    // Memory response coincident with flush is discarded
    start_miss(32'h200);
    flush = 1'b1; mem_valid = 1'b1; mem_inst = 32'hdead_beef;
    @(negedge clk);
    flush = 1'b0; mem_valid = 1'b0;
    chk("flushresp_mem_drop", 32'(mem_en), 32'd0);
    chk("flushresp_no_pulse", 32'(dec_en), 32'd0);
    @(negedge clk);
    req_miss(32'h200, 1'b0, 32'h0040_0213, 1);

    // Flush with redirect to cached 0x100
    start_miss(32'h300);
    sb_q.push_back('{inst: 32'h0010_0093, pc: 32'h100, pred: 1'b1});
    flush = 1'b1;
    issue(32'h100, 1'b1);
    flush = 1'b0;
    chk("redirect_mem_drop", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("redirect_pulse", 32'(dec_en), 32'd1);
    chk("redirect_pred", 32'(dec_pred), 32'd1);
    @(negedge clk);
    chk("redirect_pulse_end", 32'(dec_en), 32'd0);

    // in_rdy low mid-MISS freezes everything
    issue(32'h504, 1'b1);
    @(negedge clk);
    chk("rdy_mem_en", 32'(mem_en), 32'd1);
    sb_q.push_back('{inst: 32'h0050_0293, pc: 32'h504, pred: 1'b1});
    rdy = 1'b0; mem_valid = 1'b1; mem_inst = 32'h0050_0293;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rdy_hold_mem", 32'(mem_en), 32'd1);
      chk("rdy_no_pulse", 32'(dec_en), 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("rdy_pulse", 32'(dec_en), 32'd1);
    chk("rdy_mem_drop", 32'(mem_en), 32'd0);
    @(negedge clk);
    req_hit(32'h504, 1'b1, 32'h0050_0293);
    req_hit(32'h100, 1'b1, 32'h0010_0093);

    // Reset mid-MISS clears state and cache
    start_miss(32'h600);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mid_pc", dec_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_miss(32'h0, 1'b0, 32'h0000_0013, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
